// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage RV32I core.
// Captures decoded control and operands into EX, detects load-use hazards
// against the instruction currently in EX, and inserts bubbles for hazards
// and branch flushes. A saturating counter tracks how many real
// instructions were displaced by a bubble.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_memread,
    input  logic             id_memtoreg,
    input  logic             id_memwrite,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_branch,
    output logic             ex_memread,
    output logic             ex_memtoreg,
    output logic             ex_memwrite,
    output logic             ex_alusrc,
    output logic             ex_regwrite,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic rs1_used;
    logic rs2_used;
    logic hazard;
    logic insert_bubble;

    logic             ex_valid_d,    ex_valid_q;
    logic             ex_branch_d,   ex_branch_q;
    logic             ex_memread_d,  ex_memread_q;
    logic             ex_memtoreg_d, ex_memtoreg_q;
    logic             ex_memwrite_d, ex_memwrite_q;
    logic             ex_alusrc_d,   ex_alusrc_q;
    logic             ex_regwrite_d, ex_regwrite_q;
    logic [XLEN-1:0]  ex_pc_d,       ex_pc_q;
    logic [XLEN-1:0]  ex_rs1_data_d, ex_rs1_data_q;
    logic [XLEN-1:0]  ex_rs2_data_d, ex_rs2_data_q;
    logic [XLEN-1:0]  ex_imm_d,      ex_imm_q;
    logic [4:0]       ex_rs1_d,      ex_rs1_q;
    logic [4:0]       ex_rs2_d,      ex_rs2_q;
    logic [4:0]       ex_rd_d,       ex_rd_q;
    logic [2:0]       ex_funct3_d,   ex_funct3_q;
    logic             ex_funct7b5_d, ex_funct7b5_q;
    logic [CNT_W-1:0] bubble_count_d, bubble_count_q;

    // Load-use hazard detection; stores still stall on rs2 since there is no MEM-to-MEM path.
    always_comb begin
        rs1_used      = id_regwrite | id_memwrite | id_branch;
        rs2_used      = (id_regwrite & ~id_alusrc) | id_memwrite | id_branch;
        hazard        = id_valid & ex_valid_q & ex_memread_q & (ex_rd_q != 5'd0) &
                        ((rs1_used & (ex_rd_q == id_rs1)) | (rs2_used & (ex_rd_q == id_rs2)));
        insert_bubble = flush | hazard;
        stall         = hazard & ~flush;
    end

    // Next EX contents: bubble on flush or hazard, otherwise capture decode.
    // Bubbles keep the old operand fields; only valid and control must clear.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_branch_d   = ex_branch_q;
        ex_memread_d  = ex_memread_q;
        ex_memtoreg_d = ex_memtoreg_q;
        ex_memwrite_d = ex_memwrite_q;
        ex_alusrc_d   = ex_alusrc_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_funct3_d   = ex_funct3_q;
        ex_funct7b5_d = ex_funct7b5_q;
        if (insert_bubble) begin
            ex_valid_d    = 1'b0;
            ex_branch_d   = 1'b0;
            ex_memread_d  = 1'b0;
            ex_memtoreg_d = 1'b0;
            ex_memwrite_d = 1'b0;
            ex_alusrc_d   = 1'b0;
            ex_regwrite_d = 1'b0;
        end else begin
            ex_valid_d    = id_valid;
            ex_branch_d   = id_branch   & id_valid;
            ex_memread_d  = id_memread  & id_valid;
            ex_memtoreg_d = id_memtoreg & id_valid;
            ex_memwrite_d = id_memwrite & id_valid;
            ex_alusrc_d   = id_alusrc   & id_valid;
            ex_regwrite_d = id_regwrite & id_valid;
            ex_pc_d       = id_pc;
            ex_rs1_data_d = id_rs1_data;
            ex_rs2_data_d = id_rs2_data;
            ex_imm_d      = id_imm;
            ex_rs1_d      = id_rs1;
            ex_rs2_d      = id_rs2;
            ex_rd_d       = id_rd;
            ex_funct3_d   = id_funct3;
            ex_funct7b5_d = id_funct7b5;
        end
    end

    // Saturating count of real instructions displaced by a bubble.
    always_comb begin
        bubble_count_d = bubble_count_q;
        if (insert_bubble && id_valid && (bubble_count_q != CNT_MAX)) begin
            bubble_count_d = bubble_count_q + CNT_W'(1);
        end
    end

    // Pipeline register and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_branch_q    <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_memtoreg_q  <= 1'b0;
            ex_memwrite_q  <= 1'b0;
            ex_alusrc_q    <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_pc_q        <= '0;
            ex_rs1_data_q  <= '0;
            ex_rs2_data_q  <= '0;
            ex_imm_q       <= '0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_funct3_q    <= '0;
            ex_funct7b5_q  <= 1'b0;
            bubble_count_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_branch_q    <= ex_branch_d;
            ex_memread_q   <= ex_memread_d;
            ex_memtoreg_q  <= ex_memtoreg_d;
            ex_memwrite_q  <= ex_memwrite_d;
            ex_alusrc_q    <= ex_alusrc_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_pc_q        <= ex_pc_d;
            ex_rs1_data_q  <= ex_rs1_data_d;
            ex_rs2_data_q  <= ex_rs2_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_funct3_q    <= ex_funct3_d;
            ex_funct7b5_q  <= ex_funct7b5_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_branch    = ex_branch_q;
    assign ex_memread   = ex_memread_q;
    assign ex_memtoreg  = ex_memtoreg_q;
    assign ex_memwrite  = ex_memwrite_q;
    assign ex_alusrc    = ex_alusrc_q;
    assign ex_regwrite  = ex_regwrite_q;
    assign ex_pc        = ex_pc_q;
    assign ex_rs1_data  = ex_rs1_data_q;
    assign ex_rs2_data  = ex_rs2_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign ex_funct3    = ex_funct3_q;
    assign ex_funct7b5  = ex_funct7b5_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the five-stage RV32I core; sits directly downstream of the decode control unit.
- Registers decoded control bits and operands into EX, and detects load-use hazards against the instruction already in EX.
- Stalls fetch/decode and inserts bubbles for hazards and branch flushes.
- Keeps a saturating count of inserted bubbles for performance monitoring.

Parameters:
- XLEN, 32, datapath width of pc, register data and immediate.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  control bits from decode.
- id_pc  in  XLEN  instruction address.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_funct3  in  3  funct3 field.
- id_funct7b5  in  1  instruction bit 30.
- flush  in  1  branch taken in EX; squash the instruction in decode.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  EX holds a real instruction.
- ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered control bits.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered operands.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices.
- ex_funct3  out  3  registered funct3.
- ex_funct7b5  out  1  registered bit 30.
- bubble_count  out  CNT_W  bubbles inserted since reset, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): all ex_* outputs, ex_valid and bubble_count go to 0. The register then holds a NOP bubble.
- rs1_used = id_regwrite | id_memwrite | id_branch.
- rs2_used = (id_regwrite & ~id_alusrc) | id_memwrite | id_branch. This covers R-type, store and branch.
- hazard = id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((rs1_used & ex_rd == id_rs1) | (rs2_used & ex_rd == id_rs2)).
- stall = hazard & ~flush. Purely combinational, same cycle, no register.
- Next-state priority each rising edge:
  1. flush = 1: load a bubble (ex_valid = 0, all six control bits = 0). The flush overrides any hazard.
  2. Else hazard = 1: load a bubble. Decode holds the instruction because stall = 1.
  3. Else: capture all id_* fields. ex_valid = id_valid. Control bits are forced to 0 when id_valid = 0.
- Bubble contents: operand, index and funct fields may keep any value. Control bits and ex_valid must be 0.
- Latency: one cycle from id_* to ex_*.
- Load-use timing: exactly one bubble per load-use pair. On the next cycle the load has left EX, so the hazard clears and the held instruction is captured.
- bubble_count increments by 1 on every edge where case 1 or case 2 applies and id_valid = 1. It holds at 2^CNT_W-1 (no wrap).
- Register x0: ex_rd = 0 never raises a hazard.
- A store whose rs2 matches a load's rd still stalls. There is no MEM-to-MEM forwarding.
- Reset asserted mid-stall: outputs clear immediately and stall drops. After release the first valid capture proceeds normally.

Test Plan:
- Reset: drive all inputs non-zero with rst_n = 0 -> all ex_* = 0, bubble_count = 0, stall = 0. After release, ADDI x5 (id_regwrite = 1, id_alusrc = 1, id_imm = 7) -> ex_rd = 5, ex_imm = 7, ex_regwrite = 1 one edge later.
- Load-use: LW x6 into EX, then ADD x7, x6, x1 in ID -> stall = 1 for exactly one cycle, ex_valid = 0 for that edge, ADD captured on the next edge, bubble_count = 1.
- Rs2-only use: LW x6 then ADDI x7, x6? No, use ADDI x7, x1 with id_rs2 = 6 (alusrc = 1) -> no stall. SW with rs2 = 6 -> stall = 1.
- x0 destination: LW with ex_rd = 0, followed by ADD x3, x0, x0 -> stall = 0, no bubble.
- Flush with hazard: flush = 1 in the same cycle as a load-use hazard -> stall = 0, bubble loaded, bubble_count +1.
- Saturation: with CNT_W = 2, force 5 flushes with id_valid = 1 -> bubble_count = 3 and holds at 3.
